div_issue: RTL and testbench
============================

Name: div_issue

Overview:
- Request front-end that sits directly upstream of the 16-bit iterative divider.
- Accepts divide commands from the execute stage over a valid/ready interface and buffers them in a small FIFO.
- Converts signed operations into magnitude divisions, launches the divider with a start pulse, and waits for its rdy pulse.
- Applies the sign fix-up and returns each result over a held valid/ready response port.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
W, 16, operand/result width (must match divider)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_a  in  W  dividend
req_b  in  W  divisor
req_op  in  2  00 unsigned quotient, 01 unsigned remainder, 10 signed quotient, 11 signed remainder
div_start  out  1  one-cycle start pulse to divider
div_mode  out  1  0 quotient, 1 remainder
div_num1  out  W  dividend magnitude
div_num2  out  W  divisor magnitude
div_work  in  1  divider busy
div_rdy  in  1  divider result pulse (one cycle)
div_result  in  W  divider result, valid while div_rdy=1
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  consumer accepts
rsp_data  out  W  final result
rsp_div0  out  1  divisor was zero

Behaviour:
- Reset, async: FIFO empty, FSM IDLE, rsp_valid=0, rsp_data=0, rsp_div0=0, div_start=0, div_mode=0, div_num1=0, div_num2=0. req_ready=1 once rst deasserts.
- Push: on req_valid&&req_ready. req_ready = !full, and depends only on occupancy. A pop in the same cycle never admits a push when full.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
- FSM IDLE:
  - If the FIFO is non-empty and div_work=0, pop the head into operand registers and go to LAUNCH.
  - Signed ops: sa=a[W-1], sb=b[W-1]; num1 = sa ? -a : a, num2 = sb ? -b : b.
  - Unsigned ops: operands pass through unchanged.
  - Latch the op and the divisor-zero flag (b==0).
- FSM LAUNCH: div_start=1 for exactly this cycle; div_num1, div_num2 and div_mode are stable from register outputs. Next state WAIT.
- FSM WAIT:
  - div_start=0. On div_rdy, capture div_result and go to RESP.
  - div_rdy in any other state is ignored.
  - No timeout: the divider always completes, taking at most 2*quotient+3 cycles.
- Fix-up at capture, registered into rsp_data:
  - Signed quotient with sa^sb=1: rsp_data = -div_result. Otherwise the raw result.
  - Signed remainder with sa=1: rsp_data = -div_result. The remainder takes the dividend's sign.
  - Divide-by-zero: quotient ops return 16'hFFFF unmodified for any sign; remainder ops return the original req_a, not the magnitude. rsp_div0=1.
  - Overflow -32768/-1: magnitude 0x8000, quotient 0x8000 after wrap. No flag.
  - All arithmetic is modulo 2^W.
- FSM RESP: rsp_valid=1 with rsp_data and rsp_div0 held stable. On rsp_ready, go to IDLE next cycle and rsp_valid drops.
- Latency: a request pushed into an empty FIFO at edge N gives LAUNCH at N+1 and start seen by the divider at N+2. rsp_valid rises the cycle after div_rdy.
- Ordering: responses are strictly in request order; one division is outstanding at a time.
- Reset mid-operation clears everything. The divider shares rst, so no orphan div_rdy can occur.
- Pushes continue during LAUNCH, WAIT and RESP until the FIFO is full.

Decomposition:
- Shared package holds:
  - op encodings: OP_UQ, OP_UR, OP_SQ, OP_SR;
  - FSM state constants: IDLE, LAUNCH, WAIT, RESP;
  - DIV0_QUOT = 16'hFFFF.
- One natural sub-module, div_req_fifo: a synchronous DEPTH x (2W+2) FIFO with push, pop, full, empty and head data. div_issue instantiates it.

Test Plan:
- Unsigned quotient and remainder: op=00 a=100 b=7 -> rsp_data=14 (0x000E), rsp_div0=0. op=01 same operands -> rsp_data=2. Check start seen on the divider 2 cycles after push.
- Signed: op=10 a=0xFF9C(-100) b=7 -> div_num1=100, rsp_data=0xFFF2(-14). op=11 same operands -> 0xFFFE(-2). op=10 a=-100 b=-7 -> 0x000E.
- Divide-by-zero: op=00 a=25 b=0 -> rsp_data=0xFFFF, rsp_div0=1. op=11 a=0xFFE7 b=0 -> rsp_data=0xFFE7, rsp_div0=1.
- Back-pressure: hold rsp_ready=0 and push 5 requests -> req_ready drops after the FIFO fills. Release rsp_ready -> 5 responses return in order, each held stable while waiting.
- Overflow: op=10 a=0x8000 b=0xFFFF -> rsp_data=0x8000, rsp_div0=0.
- Reset mid-op: assert rst during WAIT with 3 entries queued -> all outputs at reset values immediately. After release, a new request 9/3 -> rsp_data=3.

Source files
------------

// File: rtl/div_issue_pkg.sv
// div_issue_pkg
//   Shared definitions for the divider issue front-end: request op
//   encodings, issue FSM states and the divide-by-zero quotient value.
package div_issue_pkg;

    // Request op encodings as presented on req_op.
    typedef enum logic [1:0] {
        OP_UQ = 2'b00,   // unsigned quotient
        OP_UR = 2'b01,   // unsigned remainder
        OP_SQ = 2'b10,   // signed quotient
        OP_SR = 2'b11    // signed remainder
    } op_e;

    // Issue FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_e;

    // Quotient returned for any divide-by-zero, regardless of operand signs.
    localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

    // Bit 1 of the op selects signed handling.
    function automatic logic op_signed(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo
//   Synchronous DEPTH x DW request FIFO. Pointers carry one extra wrap bit
//   so full and empty are distinguished without a separate counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers only)
//   i_push       write i_wdata (ignored while full)
//   i_pop        advance head (ignored while empty)
//   i_wdata      entry to write
//   o_full       no free entries
//   o_empty      no stored entries
//   o_rdata      head entry, valid while !o_empty
module div_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_empty = (r_wr == r_rd);
    // Same slot, opposite lap.
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_rdata = r_mem[r_rd[AW-1:0]];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/div_issue.sv
// div_issue
//   Front-end for the iterative divider. Buffers divide requests, turns
//   signed ops into magnitude divisions, launches the divider, applies the
//   sign / divide-by-zero fix-up and returns results in request order.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready = FIFO not full)
//   req_a, req_b, req_op           dividend, divisor, op (see op_e)
//   div_start                      one-cycle start pulse to the divider
//   div_mode                       0 quotient, 1 remainder
//   div_num1, div_num2             dividend / divisor magnitudes
//   div_work, div_rdy, div_result  divider busy, result pulse, result
//   rsp_valid/rsp_ready            response handshake, held until accepted
//   rsp_data, rsp_div0             final result, divisor-was-zero flag
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [1:0]   req_op,
    output logic         div_start,
    output logic         div_mode,
    output logic [W-1:0] div_num1,
    output logic [W-1:0] div_num2,
    input  logic         div_work,
    input  logic         div_rdy,
    input  logic [W-1:0] div_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_div0
);

    localparam int FW = 2*W + 2;

    // FIFO
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [FW-1:0] w_wdata;
    logic [FW-1:0] w_head;
    op_e           w_hop;
    logic [W-1:0]  w_ha;
    logic [W-1:0]  w_hb;
    logic          w_hsa;
    logic          w_hsb;

    assign req_ready = !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_wdata   = {req_op, req_a, req_b};

    div_req_fifo #(.DEPTH(DEPTH), .DW(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_head)
    );

    assign w_hop = op_e'(w_head[FW-1 -: 2]);
    assign w_ha  = w_head[2*W-1 -: W];
    assign w_hb  = w_head[W-1:0];
    // Sign bits only matter for signed ops; unsigned operands pass through.
    assign w_hsa = op_signed(w_hop) && w_ha[W-1];
    assign w_hsb = op_signed(w_hop) && w_hb[W-1];

    // FSM
    state_e r_state;
    state_e w_next;
    logic   w_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !div_work) begin
                    w_pop  = 1'b1;
                    w_next = LAUNCH;
                end
            end
            LAUNCH: w_next = WAIT;
            WAIT: begin
                if (div_rdy) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign div_start = (r_state == LAUNCH);
    assign rsp_valid = (r_state == RESP);

    // Operand registers
    logic [W-1:0] r_num1;
    logic [W-1:0] r_num2;
    logic [W-1:0] r_a;
    logic         r_mode;
    op_e          r_op;
    logic         r_sa;
    logic         r_sb;
    logic         r_div0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num1 <= '0;
            r_num2 <= '0;
            r_a    <= '0;
            r_mode <= 1'b0;
            r_op   <= OP_UQ;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_div0 <= 1'b0;
        end else if (w_pop) begin
            r_num1 <= w_hsa ? -w_ha : w_ha;
            r_num2 <= w_hsb ? -w_hb : w_hb;
            r_a    <= w_ha;
            r_mode <= w_hop[0];
            r_op   <= w_hop;
            r_sa   <= w_hsa;
            r_sb   <= w_hsb;
            r_div0 <= (w_hb == '0);
        end
    end

    assign div_num1 = r_num1;
    assign div_num2 = r_num2;
    assign div_mode = r_mode;

    // Result fix-up. Remainder takes the dividend's sign; divide-by-zero
    // bypasses the divider result and returns fixed / original values.
    logic [W-1:0] w_fix;

    always_comb begin
        w_fix = div_result;
        if (r_div0)
            w_fix = r_mode ? r_a : W'(DIV0_QUOT);
        else if (r_op == OP_SQ && (r_sa ^ r_sb))
            w_fix = -div_result;
        else if (r_op == OP_SR && r_sa)
            w_fix = -div_result;
    end

    logic [W-1:0] r_rsp_data;
    logic         r_rsp_div0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_div0 <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= w_fix;
            r_rsp_div0 <= r_div0;
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_div0 = r_rsp_div0;

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [1:0]   req_op;
    logic         div_start;
    logic         div_mode;
    logic [W-1:0] div_num1;
    logic [W-1:0] div_num2;
    logic         div_work;
    logic         div_rdy;
    logic [W-1:0] div_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_div0;

    int errors = 0;
    int checks = 0;

    div_issue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .div_start  (div_start),
        .div_mode   (div_mode),
        .div_num1   (div_num1),
        .div_num2   (div_num2),
        .div_work   (div_work),
        .div_rdy    (div_rdy),
        .div_result (div_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_div0   (rsp_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: plain division on the magnitudes after a random delay.
    int           lat_min = 1;
    int           lat_max = 4;
    int           d_cnt;
    logic         d_busy;
    logic [W-1:0] d_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_busy     <= 1'b0;
            d_cnt      <= 0;
            d_res      <= '0;
            div_rdy    <= 1'b0;
            div_result <= '0;
        end else begin
            div_rdy <= 1'b0;
            if (div_start) begin
                d_busy <= 1'b1;
                d_cnt  <= $urandom_range(lat_max, lat_min);
                if (div_num2 == 0) d_res <= div_mode ? div_num1 : 16'hFFFF;
                else               d_res <= div_mode ? div_num1 % div_num2 : div_num1 / div_num2;
            end else if (d_busy) begin
                if (d_cnt <= 1) begin
                    d_busy     <= 1'b0;
                    div_rdy    <= 1'b1;
                    div_result <= d_res;
                end else begin
                    d_cnt <= d_cnt - 1;
                end
            end
        end
    end
    assign div_work = d_busy;

    // Reference: {div0, result} from plain integer arithmetic.
    function automatic logic [16:0] ref_div(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        if (b == 0) return {1'b1, (op[0] ? a : 16'hFFFF)};
        if (op[1]) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {16'd0, a};
            sb = {16'd0, b};
        end
        r = op[0] ? (sa % sb) : (sa / sb);
        return {1'b0, r[15:0]};
    endfunction

    logic [16:0] exp_q[$];
    bit          rnd_ready = 0;

    task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(input int n, input string name);
        int got = 0;
        int budget = 0;
        logic [16:0] e;
        while (got < n && budget < 3000) begin
            @(negedge clk);
            budget++;
            rsp_ready = rnd_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra: got %h with nothing expected", name, {rsp_div0, rsp_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_div0, rsp_data} !== e) begin
                        errors++;
                        $display("FAIL %s[%0d]: got div0=%0b data=%h required div0=%0b data=%h",
                                 name, got, rsp_div0, rsp_data, e[16], e[15:0]);
                    end
                end
                got++;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (got < n) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d responses required %0d", name, got, n);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({rsp_valid, rsp_data, rsp_div0, div_start, div_mode, div_num1, div_num2, req_ready} !==
            {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h div0=%0b start=%0b mode=%0b n1=%h n2=%h ready=%0b required reset values",
                     name, rsp_valid, rsp_data, rsp_div0, div_start, div_mode, div_num1, div_num2, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_unsigned();
        // Launch timing: push at edge N, LAUNCH (start high) after N+1.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 16'd100; req_b = 16'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_q.push_back({1'b0, 16'h000E});
        checks++;
        if (div_start !== 1'b0) begin
            errors++; $display("FAIL start_early: got %0b required 0", div_start);
        end
        @(posedge clk); #1;
        checks++;
        if ({div_start, div_mode, div_num1, div_num2} !== {1'b1, 1'b0, 16'd100, 16'd7}) begin
            errors++;
            $display("FAIL launch_uq: got start=%0b mode=%0b n1=%h n2=%h required 1 0 0064 0007",
                     div_start, div_mode, div_num1, div_num2);
        end
        @(posedge clk); #1;
        checks++;
        if (div_start !== 1'b0) begin
            errors++; $display("FAIL start_pulse_width: got %0b required 0", div_start);
        end
        collect(1, "uq");
        push(2'b01, 16'd100, 16'd7);
        exp_q.push_back({1'b0, 16'd2});
        collect(1, "ur");
    endtask

    task automatic test_signed();
        push(2'b10, 16'hFF9C, 16'd7);
        exp_q.push_back({1'b0, 16'hFFF2});
        @(posedge clk); #1;
        checks++;
        if ({div_start, div_mode, div_num1, div_num2} !== {1'b1, 1'b0, 16'd100, 16'd7}) begin
            errors++;
            $display("FAIL launch_sq: got start=%0b mode=%0b n1=%h n2=%h required 1 0 0064 0007",
                     div_start, div_mode, div_num1, div_num2);
        end
        collect(1, "sq_neg_pos");
        push(2'b11, 16'hFF9C, 16'd7);
        exp_q.push_back({1'b0, 16'hFFFE});
        collect(1, "sr_neg_pos");
        push(2'b10, 16'hFF9C, 16'hFFF9);
        exp_q.push_back({1'b0, 16'h000E});
        collect(1, "sq_neg_neg");
    endtask

    task automatic test_div0_overflow();
        push(2'b00, 16'd25, 16'd0);
        exp_q.push_back({1'b1, 16'hFFFF});
        collect(1, "uq_div0");
        push(2'b11, 16'hFFE7, 16'd0);
        exp_q.push_back({1'b1, 16'hFFE7});
        collect(1, "sr_div0");
        push(2'b10, 16'h8000, 16'hFFFF);
        exp_q.push_back({1'b0, 16'h8000});
        collect(1, "sq_overflow");
    endtask

    task automatic test_back_to_back();
        logic [15:0] held;
        logic        held_div0;
        int          n = 0;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 2'(i % 4);
            a  = 16'(1000 + 37 * i) ^ (i[0] ? 16'h8000 : 16'h0);
            b  = 16'(3 + i);
            push(op, a, b);
            exp_q.push_back(ref_div(op, a, b));
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: req_ready got %0b required 0", req_ready);
        end
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        held = rsp_data;
        held_div0 = rsp_div0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_div0, rsp_data} !== {1'b1, held_div0, held}) begin
                errors++;
                $display("FAIL bp_hold: got valid=%0b div0=%0b data=%h required 1 %0b %h",
                         rsp_valid, rsp_div0, rsp_data, held_div0, held);
            end
        end
        collect(5, "bp_order");
    endtask

    task automatic test_random();
        rnd_ready = 1;
        fork
            begin
                logic [15:0] a;
                logic [15:0] b;
                logic [1:0]  op;
                for (int i = 0; i < 40; i++) begin
                    op = 2'($urandom_range(3, 0));
                    case ($urandom_range(5, 0))
                        0:       b = 16'h0000;
                        1:       b = 16'hFFFF;
                        2:       b = 16'($urandom_range(15, 1));
                        default: b = 16'($urandom);
                    endcase
                    a = ($urandom_range(5, 0) == 0) ? 16'h8000 : 16'($urandom);
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                    push(op, a, b);
                    exp_q.push_back(ref_div(op, a, b));
                end
            end
            collect(40, "random");
        join
        rnd_ready = 0;
    endtask

    task automatic test_reset_midop();
        lat_min = 30; lat_max = 30;
        rsp_ready = 1'b0;
        push(2'b10, 16'hFF00, 16'd3);
        push(2'b00, 16'd50, 16'd5);
        push(2'b01, 16'd51, 16'd5);
        push(2'b11, 16'hFFF1, 16'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_midop");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        lat_min = 1; lat_max = 4;
        push(2'b00, 16'd9, 16'd3);
        exp_q.push_back({1'b0, 16'd3});
        collect(1, "after_reset");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div0_overflow();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
